// File: rtl/riscv_consts_pkg.sv
// Shared Riscv151 constants and the {pc, instruction} record carried by the fetch front end.
package riscv_consts;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits carry no meaning.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with flush and a registered head.
import riscv_consts::*;

module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  fetch_entry_t             i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  fetch_entry_t r_head;
  fetch_entry_t w_head_nxt;
  logic [AW:0]  r_rd;
  logic [AW:0]  r_wr;
  logic [AW:0]  r_count;
  logic [AW:0]  w_rd_nxt;
  logic [AW:0]  w_wr_nxt;
  logic [AW:0]  w_count_nxt;
  logic         w_full;
  logic         w_push;
  logic         w_pop;

  // Next pointers/count, and the entry that will sit at the head after this edge.
  always_comb begin
    w_full      = (r_count == (AW+1)'(DEPTH));
    w_push      = i_push && !w_full;
    w_pop       = i_pop && (r_count != '0);
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_count_nxt = r_count;
    w_head_nxt  = '0;
    if (i_flush) begin
      w_rd_nxt    = '0;
      w_wr_nxt    = '0;
      w_count_nxt = '0;
      w_head_nxt  = '0;
    end else begin
      w_rd_nxt    = r_rd + (AW+1)'(w_pop);
      w_wr_nxt    = r_wr + (AW+1)'(w_push);
      w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // A push into an (effectively) empty queue bypasses storage to the head.
      if (w_count_nxt == '0) begin
        w_head_nxt = '0;
      end else if (w_push && (w_rd_nxt == r_wr)) begin
        w_head_nxt = i_wdata;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  fetch_queue_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_push),
    .i_full  (w_full),
    .i_flush (i_flush)
  );

endmodule

// File: rtl/fetch_queue_chk.sv
// Protocol checker for fetch_queue: a push must never land on a full queue.
module fetch_queue_chk (
  input logic clk,
  input logic rst,
  input logic i_push,
  input logic i_full,
  input logic i_flush
);

  a_no_push_on_full: assert property (@(posedge clk) disable iff (rst)
    !(i_push && i_full && !i_flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited IMEM reads,
// queues returned words and handles EX redirects with flush of queued/in-flight fetches.
import riscv_consts::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          ADDR_BITS   = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_en,
  output logic [ADDR_BITS-1:0]           imem_addr,
  input  logic [31:0]                    imem_rdata,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic                           inst_valid,
  input  logic                           inst_ready,
  output logic [31:0]                    inst_data,
  output logic [31:0]                    inst_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]   r_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [CW:0]   w_used;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  // Credit counts the in-flight word as occupied; a same-cycle pop frees nothing.
  always_comb begin
    w_used  = (CW+1)'(w_count) + (CW+1)'(r_inflight);
    w_issue = !rst && !redirect_valid && (w_used < (CW+1)'(QUEUE_DEPTH));
    w_push  = r_inflight && !redirect_valid;
    w_pop   = inst_valid && inst_ready;
    w_wdata = '{pc: r_inflight_pc, inst: imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
    end else if (redirect_valid) begin
      r_pc       <= align_word(redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_valid (inst_valid),
    .o_count (w_count)
  );

  assign imem_en     = w_issue;
  assign imem_addr   = r_pc[ADDR_BITS+1:2];
  assign inst_data   = w_head.inst;
  assign inst_pc     = w_head.pc;
  assign queue_count = w_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC-stream scoreboard checked every cycle plus literal timing checks.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  queue_count;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;
  int hs0;

  logic [31:0] exp_pc = RESET_PC;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_data;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [11:0] a);
    return 32'h1000_0000 + {20'h0, a};
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memword(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next PC of the architectural stream.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc     = RESET_PC;
      prev_stall = 1'b0;
    end else begin
      if (inst_valid) chk("head_data", inst_data, memword(inst_pc[13:2]));
      chk("count_bound", {31'h0, (queue_count <= 3'd4)}, 32'd1);
      if (prev_stall) begin
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_data", inst_data, prev_data);
      end
      if (inst_valid && inst_ready) begin
        chk("stream_pc", inst_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n_hs++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_pc    = inst_pc;
      prev_data  = inst_data;
    end
  end

  initial begin
    // Reset values
    cyc(); cyc(); #1;
    chk("rst_en", imem_en, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_count", queue_count, 32'd0);

    // First fetch and steady streaming
    rst = 1'b0; #1;
    chk("c0_en", imem_en, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    cyc(); #1;
    chk("c1_valid", inst_valid, 32'd0);
    cyc(); #1;
    chk("c2_valid", inst_valid, 32'd1);
    chk("c2_pc", inst_pc, 32'h4000_0000);
    chk("c2_data", inst_data, 32'h1000_0000);
    chk("c2_count", queue_count, 32'd1);
    cyc(); #1;
    chk("c3_pc", inst_pc, 32'h4000_0004);
    chk("c3_data", inst_data, 32'h1000_0001);
    repeat (4) begin
      cyc(); #1;
      chk("steady_count", queue_count, 32'd1);
      chk("steady_en", imem_en, 32'd1);
    end

    // Stall fills queue to depth then resumes sequentially
    inst_ready = 1'b0;
    repeat (10) cyc();
    #1;
    chk("stall_count", queue_count, 32'd4);
    chk("stall_en", imem_en, 32'd0);
    chk("stall_valid", inst_valid, 32'd1);
    inst_ready = 1'b1;
    repeat (8) cyc();

    // Redirect coinciding with a handshake and a push
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_0103;
    hs0 = n_hs;
    #1;
    chk("rd_t_en", imem_en, 32'd0);
    chk("rd_t_valid", inst_valid, 32'd1);
    cyc();
    redirect_valid = 1'b0; #1;
    chk("rd_t1_count", queue_count, 32'd0);
    chk("rd_t1_addr", imem_addr, 32'h040);
    chk("rd_t1_en", imem_en, 32'd1);
    chk("rd_hs_once", n_hs, hs0 + 1);
    cyc(); #1;
    chk("rd_t2_valid", inst_valid, 32'd0);
    cyc(); #1;
    chk("rd_t3_valid", inst_valid, 32'd1);
    chk("rd_t3_pc", inst_pc, 32'h4000_0100);
    chk("rd_t3_data", inst_data, 32'h1000_0040);
    repeat (3) cyc();

    // Reset with a full queue
    inst_ready = 1'b0;
    repeat (8) cyc();
    #1;
    chk("full_count", queue_count, 32'd4);
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    chk("mrst_valid", inst_valid, 32'd0);
    chk("mrst_count", queue_count, 32'd0);
    chk("mrst_pc", inst_pc, 32'h0);
    chk("mrst_data", inst_data, 32'h0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_en", imem_en, 32'd1);
    inst_ready = 1'b1;
    cyc(); cyc(); #1;
    chk("mrst_refetch_pc", inst_pc, 32'h4000_0000);
    chk("mrst_refetch_data", inst_data, 32'h1000_0000);
    repeat (3) cyc();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 32'hFFF);
    chk("wrap_en", imem_en, 32'd1);
    cyc(); #1;
    chk("wrap_addr1", imem_addr, 32'h000);
    cyc(); #1;
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_data0", inst_data, 32'h1000_0FFF);
    cyc(); #1;
    chk("wrap_pc1", inst_pc, 32'h0000_0000);
    chk("wrap_data1", inst_data, 32'h1000_0000);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
